// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_pkg
// Purpose  : Shared counter encodings and defaults for the branch predictor.
// Revision : 1.0
// ============================================================================
package branch_predictor_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_SNT = 2'b00;
    localparam bp_ctr_t BP_WNT = 2'b01;
    localparam bp_ctr_t BP_WT  = 2'b10;
    localparam bp_ctr_t BP_ST  = 2'b11;

    localparam int BP_DEFAULT_IDX_BITS = 6;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : bp_sat_counter
// Purpose  : Next-state function of a 2-bit saturating direction counter.
// Revision : 1.0
// ============================================================================
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    input  logic       enable,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (enable) begin
            if (taken) begin
                if (ctr != BP_ST) ctr_next = ctr + 2'd1;
            end else begin
                if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped 2-bit predictor with BTB, mispredict redirect, stats.
// Revision : 1.0
// ============================================================================
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = BP_DEFAULT_IDX_BITS,
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // Flop arrays: reset must clear every entry and lookup is an async read.
    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    bp_ctr_t             r_ctr    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];

    logic                r_redirect_valid;
    logic [31:0]         r_redirect_pc;
    logic [31:0]         r_stat_branches;
    logic [31:0]         r_stat_mispredicts;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic                w_if_hit;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [TAG_BITS-1:0] w_ex_tag;
    logic                w_ex_hit;
    bp_ctr_t             w_ctr_next;
    logic                w_mispredict;
    logic [31:0]         w_correct_pc;
    logic                w_unused;

    assign w_if_idx = if_pc[IDX_BITS+1:2];
    assign w_if_tag = if_pc[31:IDX_BITS+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign if_pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
    assign if_pred_target = if_pred_taken ? r_target[w_if_idx] : 32'd0;

    assign w_ex_idx = ex_pc[IDX_BITS+1:2];
    assign w_ex_tag = ex_pc[31:IDX_BITS+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    bp_sat_counter u_sat_counter (
        .ctr      (r_ctr[w_ex_idx]),
        .taken    (ex_taken),
        .enable   (ex_valid && w_ex_hit),
        .ctr_next (w_ctr_next)
    );

    // A taken/taken pair still mispredicts if the BTB supplied a stale target.
    assign w_mispredict = ex_valid &&
                          ((ex_taken != ex_pred_taken) ||
                           (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
    assign w_correct_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

    assign w_unused = &{1'b0, if_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= BP_WNT;
                r_target[i] <= 32'd0;
            end
        end else if (ex_valid) begin
            if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= w_ctr_next;
                if (ex_taken) r_target[w_ex_idx] <= ex_target;
            end else if (ex_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_ctr[w_ex_idx]    <= BP_WT;
                r_target[w_ex_idx] <= ex_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid   <= 1'b0;
            r_redirect_pc      <= 32'd0;
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) r_redirect_pc <= w_correct_pc;
            if (ex_valid && (r_stat_branches != 32'hFFFF_FFFF))
                r_stat_branches <= r_stat_branches + 32'd1;
            if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF))
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Self-checking bench for branch_predictor with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_branch_predictor;

    localparam int IDX_BITS = 6;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .if_pred_target   (if_pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: counter is a plain integer strength 0..3.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    bit          m_rv;
    logic [31:0] m_rpc;
    longint      m_br;
    longint      m_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_target[idx_of(pc)] : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_target[i] = 0;
        end
        m_rv = 0; m_rpc = 0; m_br = 0; m_mp = 0;
    endtask

    task automatic model_clock();
        bit mis;
        int i;
        m_rv = 0;
        if (ex_valid) begin
            mis = (ex_taken != ex_pred_taken) ||
                  (ex_taken && ex_pred_taken && ex_target != ex_pred_target);
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (mis && m_mp < 64'hFFFF_FFFF) m_mp++;
            m_rv = mis;
            if (mis) m_rpc = ex_taken ? ex_target : ex_pc + 32'd4;
            i = idx_of(ex_pc);
            if (m_hit(ex_pc)) begin
                if (ex_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (ex_taken) begin
                m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_ctr[i] = 2; m_target[i] = ex_target;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic branch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        ex_valid = 1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt;
        tick();
        ex_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
        ex_pred_taken = 0; ex_pred_target = 0; if_pc = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        if_pc = 32'h100; #1;
        tests++; if (if_pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred got=%0b exp=0", if_pred_taken); end
        tests++; if (if_pred_target !== 32'd0) begin fails++; $display("FAIL reset_target got=%h exp=0", if_pred_target); end
        tests++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin fails++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
        tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin fails++; $display("FAIL reset_redirect got=%0b/%h exp=0/0", redirect_valid, redirect_pc); end
    endtask

    task automatic test_train();
        branch(32'h100, 1, 32'h200, 0, 32'h0);
        tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin fails++; $display("FAIL train_redirect got=%0b/%h exp=1/00000200", redirect_valid, redirect_pc); end
        tests++; if (stat_mispredicts !== 32'd1 || stat_branches !== 32'd1) begin fails++; $display("FAIL train_stats got=%0d/%0d exp=1/1", stat_branches, stat_mispredicts); end
        if_pc = 32'h100; #1;
        tests++; if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h200) begin fails++; $display("FAIL train_lookup got=%0b/%h exp=1/00000200", if_pred_taken, if_pred_target); end
        tick();
        tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h200) begin fails++; $display("FAIL redirect_hold got=%0b/%h exp=0/00000200", redirect_valid, redirect_pc); end
    endtask

    task automatic test_counter();
        logic [3:0] exp_nt;
        exp_nt = 4'b0001;  // predicted taken after not-taken #1 only (bit0 = first)
        if_pc = 32'h100;
        for (int k = 0; k < 3; k++) begin
            branch(32'h100, 1, 32'h200, 1, 32'h200);
            #1;
            tests++; if (if_pred_taken !== 1'b1 || redirect_valid !== 1'b0) begin fails++; $display("FAIL ctr_taken%0d got=%0b/%0b exp=1/0", k, if_pred_taken, redirect_valid); end
        end
        for (int k = 0; k < 4; k++) begin
            branch(32'h100, 0, 32'h0, m_pred(32'h100), m_tgt(32'h100));
            #1;
            tests++; if (if_pred_taken !== exp_nt[k] || if_pred_taken !== m_pred(32'h100)) begin fails++; $display("FAIL ctr_nottaken%0d got=%0b exp=%0b", k, if_pred_taken, exp_nt[k]); end
        end
    endtask

    task automatic test_alias();
        branch(32'h100, 1, 32'h180, m_pred(32'h100), m_tgt(32'h100));
        branch(32'h200, 1, 32'h300, 0, 32'h0);
        if_pc = 32'h100; #1;
        tests++; if (if_pred_taken !== 1'b0 || if_pred_target !== 32'd0) begin fails++; $display("FAIL alias_evicted got=%0b/%h exp=0/0", if_pred_taken, if_pred_target); end
        if_pc = 32'h200; #1;
        tests++; if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h300) begin fails++; $display("FAIL alias_new got=%0b/%h exp=1/00000300", if_pred_taken, if_pred_target); end
    endtask

    task automatic test_same_cycle();
        if_pc = 32'h140;
        ex_valid = 1; ex_pc = 32'h140; ex_taken = 1; ex_target = 32'h500;
        ex_pred_taken = 0; ex_pred_target = 0;
        #1;
        tests++; if (if_pred_taken !== 1'b0) begin fails++; $display("FAIL same_cycle_pre got=%0b exp=0", if_pred_taken); end
        tick();
        ex_valid = 0; #1;
        tests++; if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h500) begin fails++; $display("FAIL same_cycle_post got=%0b/%h exp=1/00000500", if_pred_taken, if_pred_target); end
    endtask

    task automatic test_target_mismatch();
        branch(32'h180, 1, 32'h400, 1, 32'h380);
        tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin fails++; $display("FAIL tgt_mismatch got=%0b/%h exp=1/00000400", redirect_valid, redirect_pc); end
        branch(32'hFFFF_FFFC, 0, 32'h0, 1, 32'h1000);
        tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin fails++; $display("FAIL wrap got=%0b/%h exp=1/00000000", redirect_valid, redirect_pc); end
    endtask

    task automatic test_back_to_back();
        ex_valid = 1; ex_pc = 32'h600; ex_taken = 0; ex_target = 0; ex_pred_taken = 1; ex_pred_target = 32'h700;
        tick();
        tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h604) begin fails++; $display("FAIL b2b_first got=%0b/%h exp=1/00000604", redirect_valid, redirect_pc); end
        ex_pc = 32'h800; ex_taken = 1; ex_target = 32'h900; ex_pred_taken = 0;
        tick();
        tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h900) begin fails++; $display("FAIL b2b_second got=%0b/%h exp=1/00000900", redirect_valid, redirect_pc); end
        ex_valid = 0;
        tick();
        tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h900) begin fails++; $display("FAIL b2b_idle got=%0b/%h exp=0/00000900", redirect_valid, redirect_pc); end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] tgt_pool [4];
        pool = '{32'h1000, 32'h1004, 32'h1100, 32'h2000, 32'h3000, 32'h1008, 32'hFFFF_FFFC, 32'h0};
        tgt_pool = '{32'hA000, 32'hB000, 32'hC004, 32'h0000_0010};
        for (int n = 0; n < 400; n++) begin
            if_pc = pool[$urandom_range(0, 7)];
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_pc = pool[$urandom_range(0, 7)];
            ex_taken = $urandom_range(0, 1);
            ex_target = tgt_pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) begin
                ex_pred_taken = $urandom_range(0, 1); ex_pred_target = tgt_pool[$urandom_range(0, 3)];
            end else begin
                ex_pred_taken = m_pred(ex_pc); ex_pred_target = m_tgt(ex_pc);
            end
            #1;
            tests++; if (if_pred_taken !== m_pred(if_pc) || if_pred_target !== m_tgt(if_pc)) begin fails++; $display("FAIL rnd_lookup n=%0d pc=%h got=%0b/%h exp=%0b/%h", n, if_pc, if_pred_taken, if_pred_target, m_pred(if_pc), m_tgt(if_pc)); end
            tick();
            tests++; if (redirect_valid !== m_rv || redirect_pc !== m_rpc) begin fails++; $display("FAIL rnd_redirect n=%0d got=%0b/%h exp=%0b/%h", n, redirect_valid, redirect_pc, m_rv, m_rpc); end
            tests++; if (stat_branches !== m_br[31:0] || stat_mispredicts !== m_mp[31:0]) begin fails++; $display("FAIL rnd_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, stat_branches, stat_mispredicts, m_br, m_mp); end
        end
        ex_valid = 0;
    endtask

    task automatic test_reset_mid();
        branch(32'h100, 1, 32'h240, 0, 32'h0);
        tests++; if (redirect_valid !== 1'b1) begin fails++; $display("FAIL mid_pre got=%0b exp=1", redirect_valid); end
        rst_n = 0;
        model_reset();
        #1;
        if_pc = 32'h100; #1;
        tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || if_pred_taken !== 1'b0) begin fails++; $display("FAIL mid_reset got=%0b/%h/%0b exp=0/0/0", redirect_valid, redirect_pc, if_pred_taken); end
        tests++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin fails++; $display("FAIL mid_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    initial begin
        test_reset();
        test_train();
        test_counter();
        test_alias();
        test_same_cycle();
        test_target_mismatch();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
